ifetch: RTL and testbench

IFETCH -- requirements
Module: ifetch

---
 rtl/riscv_pkg.sv | 16 +
 rtl/ifetch_fifo.sv | 44 ++++
 rtl/ifetch.sv | 98 +++++++++
 tb/tb_ifetch.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// riscv_pkg: shared fetch-stage types, widths and PC helper
package riscv_pkg;
    localparam int XLEN        = 32;
    localparam int INSTR_BYTES = 4;

    typedef enum logic [1:0] {BOOT, RUN, DRAIN} fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fq_entry_t;

    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
        return pc & ~XLEN'(INSTR_BYTES - 1);
    endfunction
endpackage

// File: rtl/ifetch_fifo.sv
// ifetch_fifo: DEPTH-entry {pc,instr} prefetch queue with push/pop/flush and occupancy count
module ifetch_fifo
    import riscv_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  fq_entry_t              wdata,
    input  logic                   pop,
    input  logic                   flush,
    output fq_entry_t              rdata,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0] wp, rp;
    fq_entry_t     mem [DEPTH];

    // pointers and occupancy; flush empties the queue in one cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else if (flush) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            wp    <= wp + AW'(push);
            rp    <= rp + AW'(pop);
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    // entry storage; no reset needed since reads are qualified by count
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wp] <= wdata;
    end

    assign rdata = mem[rp];
endmodule

// File: rtl/ifetch.sv
// ifetch: credit-limited instruction prefetch with redirect flush/drain; IFETCH_PERF_EN adds perf_fetched/perf_flushed
module ifetch
    import riscv_pkg::*;
#(
    parameter int              DEPTH    = 2,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            stall,
`ifdef IFETCH_PERF_EN
    output logic [31:0]     perf_fetched,
    output logic [31:0]     perf_flushed,
`endif
    output logic            if_valid,
    output logic [XLEN-1:0] if_instr,
    output logic [XLEN-1:0] if_pc,
    output logic [XLEN-1:0] if_pc4
);
    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_e    state;
    logic [XLEN-1:0] fpc, rpc;
    logic [CW-1:0]   osd, dsc, qcnt, osd_n, dsc_n;
    logic            fire, rsp_ok, drop, push, pop;
    fq_entry_t       head;

    // responses with nothing outstanding are stale (issued before reset) and ignored
    assign rsp_ok         = imem_rsp_valid && osd != '0;
    assign imem_req_valid = state == RUN && !redirect_valid &&
                            ({1'b0, osd} + {1'b0, qcnt} < (CW+1)'(DEPTH));
    assign imem_req_addr  = fpc;
    assign fire           = imem_req_valid && imem_req_ready;
    assign drop           = rsp_ok && (dsc != '0 || redirect_valid);
    assign push           = rsp_ok && !drop;
    assign pop            = if_valid && !stall && !redirect_valid;
    assign osd_n          = osd + CW'(fire) - CW'(rsp_ok);
    assign dsc_n          = redirect_valid ? osd_n : dsc - CW'(rsp_ok && dsc != '0);

    // fetch/response PCs, credit and discard counters, and fetch mode
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= BOOT;
            fpc   <= RESET_PC;
            rpc   <= RESET_PC;
            osd   <= '0;
            dsc   <= '0;
        end else begin
            osd <= osd_n;
            dsc <= dsc_n;
            if (redirect_valid) begin
                fpc   <= align_pc(redirect_pc);
                rpc   <= align_pc(redirect_pc);
                state <= (state == DRAIN || osd_n != '0) ? DRAIN : RUN;
            end else begin
                if (fire) fpc <= fpc + XLEN'(INSTR_BYTES);
                if (push) rpc <= rpc + XLEN'(INSTR_BYTES);
                state <= (state == BOOT || (state == DRAIN && dsc_n == '0)) ? RUN : state;
            end
        end
    end

    ifetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata ('{pc: rpc, instr: imem_rsp_data}),
        .pop   (pop),
        .flush (redirect_valid),
        .rdata (head),
        .count (qcnt)
    );

    assign if_valid = qcnt != '0;
    assign if_pc    = if_valid ? head.pc : '0;
    assign if_instr = if_valid ? head.instr : '0;
    assign if_pc4   = if_pc + XLEN'(INSTR_BYTES);

`ifdef IFETCH_PERF_EN
    // delivered instructions, and queued or in-flight instructions lost to redirects
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_fetched <= '0;
            perf_flushed <= '0;
        end else begin
            perf_fetched <= perf_fetched + 32'(pop);
            perf_flushed <= perf_flushed + (redirect_valid ? 32'(qcnt) : 32'd0) + 32'(drop);
        end
    end
`endif
endmodule

// File: tb/tb_ifetch.sv
// tb_ifetch: directed self-checking bench for ifetch with a fixed-latency in-order memory model
module tb_ifetch;
    localparam logic [31:0] KEY = 32'h1357_9BDF;

    typedef struct {
        int          due;
        logic [31:0] a;
    } pend_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b1;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        stall = 1'b0;
    logic        if_valid;
    logic [31:0] if_instr, if_pc, if_pc4;
`ifdef IFETCH_PERF_EN
    logic [31:0] perf_fetched, perf_flushed;
`endif

    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    int          r0 = 0;
    int          lat = 1;
    pend_t       pend[$];
    pend_t       p;
    logic [31:0] reqq[$];
    int          reqc[$];
    logic [31:0] gotq[$];
    logic [31:0] goti[$];

    ifetch #(.DEPTH(2), .RESET_PC(32'h0)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .stall          (stall),
`ifdef IFETCH_PERF_EN
        .perf_fetched   (perf_fetched),
        .perf_flushed   (perf_flushed),
`endif
        .if_valid       (if_valid),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .if_pc4         (if_pc4)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // memory: accepted requests return in order exactly lat cycles later, data = addr ^ KEY
    always begin
        @(negedge clk);
        if (rst && imem_req_valid && imem_req_ready) pend.push_back('{cyc + lat, imem_req_addr});
        @(posedge clk);
        #1;
        if (!rst) pend.delete();
        if (pend.size() != 0 && pend[0].due <= cyc) begin
            p = pend.pop_front();
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = p.a ^ KEY;
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
        end
    end

    // record issued requests and consumed instructions
    always @(negedge clk) begin
        if (rst && imem_req_valid && imem_req_ready) begin
            reqq.push_back(imem_req_addr);
            reqc.push_back(cyc);
        end
        if (rst && if_valid && !stall && !redirect_valid) begin
            gotq.push_back(if_pc);
            goti.push_back(if_instr);
        end
    end

    task automatic clear_logs();
        reqq.delete();
        reqc.delete();
        gotq.delete();
        goti.delete();
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int l);
        rst = 1'b0;
        stall = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        imem_req_ready = 1'b1;
        lat = l;
        tick(3);
        clear_logs();
        rst = 1'b1;
        r0 = cyc;
    endtask

    task automatic wait_valid(output int c);
        c = -1;
        for (int i = 0; i < 40 && c < 0; i++) begin
            @(negedge clk);
            if (if_valid) c = cyc - r0;
        end
    endtask

    task automatic test_reset();
        int c;
        #1;
        rst = 1'b0;
        lat = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        tests++; if (imem_req_valid !== 1'b0) begin fails++; $display("FAIL reset_req_valid: got %b want 0", imem_req_valid); end
        tests++; if (if_valid !== 1'b0) begin fails++; $display("FAIL reset_if_valid: got %b want 0", if_valid); end
        tests++; if (if_pc !== 32'h0) begin fails++; $display("FAIL reset_if_pc: got %h want 0", if_pc); end
        tests++; if (if_instr !== 32'h0) begin fails++; $display("FAIL reset_if_instr: got %h want 0", if_instr); end
`ifdef IFETCH_PERF_EN
        tests++; if (perf_fetched !== 32'h0 || perf_flushed !== 32'h0) begin fails++; $display("FAIL reset_perf: got %0d/%0d want 0/0", perf_fetched, perf_flushed); end
`endif
        tick(1);
        clear_logs();
        rst = 1'b1;
        r0 = cyc;
        @(negedge clk);
        tests++; if (imem_req_valid !== 1'b0) begin fails++; $display("FAIL boot_req_valid: got %b want 0", imem_req_valid); end
        @(negedge clk);
        tests++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin fails++; $display("FAIL first_req: got %b/%h want 1/0", imem_req_valid, imem_req_addr); end
        wait_valid(c);
        tests++; if (c !== 3) begin fails++; $display("FAIL boot_latency: got %0d want 3", c); end
        tests++; if (if_pc !== 32'h0 || if_instr !== KEY) begin fails++; $display("FAIL boot_head: got %h/%h want 0/%h", if_pc, if_instr, KEY); end
        tick(10);
        for (int i = 0; i < 3; i++) begin
            tests++; if (reqq.size() <= i || reqq[i] !== 32'(4 * i)) begin fails++; $display("FAIL boot_req_seq[%0d]: got %h want %h", i, reqq[i], 4 * i); end
        end
    endtask

    task automatic test_stall();
        do_reset(1);
        stall = 1'b1;
        tick(4);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            tests++; if (imem_req_valid !== 1'b0) begin fails++; $display("FAIL stall_req_valid[%0d]: got %b want 0", i, imem_req_valid); end
            tests++; if (if_valid !== 1'b1 || if_pc !== 32'h0) begin fails++; $display("FAIL stall_hold[%0d]: got %b/%h want 1/0", i, if_valid, if_pc); end
        end
        tick(1);
        stall = 1'b0;
        tick(24);
        for (int i = 0; i < 10; i++) begin
            tests++; if (gotq.size() <= i || gotq[i] !== 32'(4 * i) || goti[i] !== (32'(4 * i) ^ KEY)) begin fails++; $display("FAIL stall_stream[%0d]: got %h/%h want %h", i, gotq[i], goti[i], 4 * i); end
            tests++; if (reqq.size() <= i || reqq[i] !== 32'(4 * i)) begin fails++; $display("FAIL stall_reqs[%0d]: got %h want %h", i, reqq[i], 4 * i); end
        end
    endtask

    task automatic test_redirect();
        int c;
        do_reset(3);
        tick(3);
        redirect_valid = 1'b1;
        redirect_pc = 32'h100;
        clear_logs();
        tick(1);
        redirect_valid = 1'b0;
        wait_valid(c);
        tests++; if (c !== 10) begin fails++; $display("FAIL redir_latency: got %0d want 10", c); end
        tests++; if (if_pc !== 32'h100 || if_pc4 !== 32'h104 || if_instr !== (32'h100 ^ KEY)) begin fails++; $display("FAIL redir_head: got %h/%h/%h want 100/104/%h", if_pc, if_pc4, if_instr, 32'h100 ^ KEY); end
        tick(4);
        tests++; if (reqq.size() < 1 || reqq[0] !== 32'h100 || reqc[0] !== r0 + 6) begin fails++; $display("FAIL redir_drain: got %h at %0d want 100 at %0d", reqq[0], reqc[0] - r0, 6); end
        tests++; if (gotq.size() < 1 || gotq[0] !== 32'h100) begin fails++; $display("FAIL redir_first: got %h want 100", gotq[0]); end
    endtask

    task automatic test_back_to_back();
        do_reset(3);
        tick(3);
        redirect_valid = 1'b1;
        redirect_pc = 32'h200;
        clear_logs();
        tick(1);
        redirect_pc = 32'h300;
        tick(1);
        redirect_valid = 1'b0;
        tick(16);
        tests++; if (reqq.size() < 2 || reqq[0] !== 32'h300 || reqq[1] !== 32'h304 || reqc[0] !== r0 + 6) begin fails++; $display("FAIL b2b_reqs: got %h,%h at %0d want 300,304 at 6", reqq[0], reqq[1], reqc[0] - r0); end
        for (int i = 0; i < 3; i++) begin
            tests++; if (gotq.size() <= i || gotq[i] !== 32'h300 + 32'(4 * i)) begin fails++; $display("FAIL b2b_stream[%0d]: got %h want %h", i, gotq[i], 32'h300 + 4 * i); end
        end
    endtask

    task automatic test_misalign();
        int c;
        do_reset(1);
        tick(1);
        redirect_valid = 1'b1;
        redirect_pc = 32'h402;
        clear_logs();
        @(negedge clk);
        tests++; if (imem_req_valid !== 1'b0) begin fails++; $display("FAIL redir_req_off: got %b want 0", imem_req_valid); end
        tick(1);
        redirect_valid = 1'b0;
        @(negedge clk);
        tests++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h400) begin fails++; $display("FAIL align_req: got %b/%h want 1/400", imem_req_valid, imem_req_addr); end
        wait_valid(c);
        tests++; if (c !== 4 || if_pc !== 32'h400) begin fails++; $display("FAIL align_head: got %h at %0d want 400 at 4", if_pc, c); end
        tick(2);
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        clear_logs();
        tick(1);
        redirect_valid = 1'b0;
        wait_valid(c);
        tests++; if (c < 0 || if_pc !== 32'hFFFF_FFFC || if_pc4 !== 32'h0) begin fails++; $display("FAIL wrap_head: got %h/%h want fffffffc/0", if_pc, if_pc4); end
        tick(10);
        tests++; if (reqq.size() < 3 || reqq[0] !== 32'hFFFF_FFFC || reqq[1] !== 32'h0 || reqq[2] !== 32'h4) begin fails++; $display("FAIL wrap_reqs: got %h,%h,%h want fffffffc,0,4", reqq[0], reqq[1], reqq[2]); end
        tests++; if (gotq.size() < 2 || gotq[1] !== 32'h0 || goti[1] !== KEY) begin fails++; $display("FAIL wrap_stream: got %h/%h want 0/%h", gotq[1], goti[1], KEY); end
    endtask

`ifdef IFETCH_PERF_EN
    task automatic test_perf();
        do_reset(3);
        tick(3);
        redirect_valid = 1'b1;
        redirect_pc = 32'h100;
        tick(1);
        redirect_valid = 1'b0;
        for (int i = 0; i < 100 && gotq.size() < 10; i++) tick(1);
        stall = 1'b1;
        @(negedge clk);
        tests++; if (gotq.size() !== 10 || perf_fetched !== 32'd10) begin fails++; $display("FAIL perf_fetched: got %0d (%0d seen) want 10", perf_fetched, gotq.size()); end
        tests++; if (perf_flushed !== 32'd2) begin fails++; $display("FAIL perf_flushed: got %0d want 2", perf_flushed); end
        stall = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_stall();
        test_redirect();
        test_back_to_back();
        test_misalign();
`ifdef IFETCH_PERF_EN
        test_perf();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, %0d tests run", tests);
        $fatal(1, "watchdog");
    end
endmodule
